// File: rtl/sha256_digest_serializer.sv
// sha256_digest_serializer: streams a captured SHA-256 digest as 32 raw bytes or 64 ASCII hex characters
module sha256_digest_serializer #(
  parameter bit ASCII_LOWER = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] hash_in,
  input  logic         hash_done,
  input  logic         hex_mode,
  output logic [7:0]   dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         dout_last,
  output logic         busy,
  output logic         overrun
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [255:0] shadow_q, shadow_d;
  logic [5:0] idx_q, idx_d;
  logic mode_q, mode_d;
  logic done_prev_q;
  logic overrun_q, overrun_d;
  logic rise, xfer, last;
  logic [7:0] raw_base, hex_base, raw_byte, hex_char;
  logic [3:0] nib;
  // MSB-first byte/nibble selection; raw index never exceeds 31, so only its low 5 bits matter
  assign raw_base = 8'd255 - {idx_q[4:0], 3'b000};
  assign hex_base = 8'd255 - {idx_q, 2'b00};
  assign raw_byte = shadow_q[raw_base -: 8];
  assign nib      = shadow_q[hex_base -: 4];
  assign hex_char = (nib < 4'd10) ? 8'h30 + {4'h0, nib}
                                  : (ASCII_LOWER ? 8'h57 : 8'h37) + {4'h0, nib};
  assign dout_valid = (state_q == SEND);
  assign busy       = dout_valid;
  assign last       = mode_q ? (idx_q == 6'd63) : (idx_q == 6'd31);
  assign dout_last  = dout_valid && last;
  assign dout       = dout_valid ? (mode_q ? hex_char : raw_byte) : 8'h00;
  assign overrun    = overrun_q;
  assign rise       = hash_done && !done_prev_q;
  assign xfer       = dout_valid && dout_ready;
  // next state: capture when idle or on the final transfer, otherwise advance and flag dropped edges
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    overrun_d = overrun_q;
    if (rise && (!dout_valid || (xfer && dout_last))) begin
      state_d  = SEND;
      shadow_d = hash_in;
      mode_d   = hex_mode;
      idx_d    = 6'd0;
    end else begin
      overrun_d = overrun_q | rise;
      if (xfer) begin
        state_d = dout_last ? IDLE : SEND;
        idx_d   = dout_last ? idx_q : idx_q + 6'd1;
      end
    end
  end
  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      idx_q       <= '0;
      mode_q      <= 1'b0;
      done_prev_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      done_prev_q <= hash_done;
      overrun_q   <= overrun_d;
    end
  end
endmodule

// File: tb/tb_sha256_digest_serializer.sv
// tb_sha256_digest_serializer: randomized and directed checks of the digest serializer against a queue model
module tb_sha256_digest_serializer;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [255:0] hash_in = '0;
  logic hash_done = 1'b0;
  logic hex_mode = 1'b0;
  logic dout_ready = 1'b0;
  logic [7:0] dout_l, dout_u;
  logic v_l, v_u, last_l, last_u, busy_l, busy_u, ovr_l, ovr_u;
  int checks = 0;
  int errors = 0;
  logic [7:0] q_l[$], q_u[$], log_l[$], log_u[$];
  logic m_prev = 1'b0;
  logic m_ovr = 1'b0;

  always #5 clk = ~clk;

  sha256_digest_serializer #(.ASCII_LOWER(1'b1)) dut_l (
    .clk(clk), .rst(rst), .hash_in(hash_in), .hash_done(hash_done), .hex_mode(hex_mode),
    .dout(dout_l), .dout_valid(v_l), .dout_ready(dout_ready), .dout_last(last_l),
    .busy(busy_l), .overrun(ovr_l));

  sha256_digest_serializer #(.ASCII_LOWER(1'b0)) dut_u (
    .clk(clk), .rst(rst), .hash_in(hash_in), .hash_done(hash_done), .hex_mode(hex_mode),
    .dout(dout_u), .dout_valid(v_u), .dout_ready(dout_ready), .dout_last(last_u),
    .busy(busy_u), .overrun(ovr_u));

  // character j of a digest rendered in the requested format
  function automatic logic [7:0] char_at(logic [255:0] d, logic hex, int j, logic lower);
    logic [3:0] n;
    if (!hex) return 8'((d >> (248 - 8 * j)) & 256'hff);
    n = 4'((d >> (252 - 4 * j)) & 256'hf);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // compare outputs against the model, then advance the model to the coming rising edge
  initial forever begin
    logic xfer, fin, rise, was_empty;
    @(negedge clk);
    if (rst) begin
      q_l.delete();
      q_u.delete();
      m_prev = 1'b0;
      m_ovr = 1'b0;
    end
    chk("valid_l", {7'b0, v_l}, {7'b0, q_l.size() != 0});
    chk("valid_u", {7'b0, v_u}, {7'b0, q_u.size() != 0});
    chk("busy_l", {7'b0, busy_l}, {7'b0, q_l.size() != 0});
    chk("busy_u", {7'b0, busy_u}, {7'b0, q_u.size() != 0});
    chk("last_l", {7'b0, last_l}, {7'b0, q_l.size() == 1});
    chk("last_u", {7'b0, last_u}, {7'b0, q_u.size() == 1});
    chk("overrun_l", {7'b0, ovr_l}, {7'b0, m_ovr});
    chk("overrun_u", {7'b0, ovr_u}, {7'b0, m_ovr});
    if (rst || q_l.size() != 0) begin
      chk("dout_l", dout_l, rst ? 8'h00 : q_l[0]);
      chk("dout_u", dout_u, rst ? 8'h00 : q_u[0]);
    end
    if (!rst) begin
      was_empty = (q_l.size() == 0);
      xfer = !was_empty && dout_ready;
      fin = xfer && q_l.size() == 1;
      rise = hash_done && !m_prev;
      if (xfer) begin
        log_l.push_back(dout_l);
        log_u.push_back(dout_u);
        void'(q_l.pop_front());
        void'(q_u.pop_front());
      end
      if (rise && (was_empty || fin)) begin
        for (int j = 0; j < (hex_mode ? 64 : 32); j++) begin
          q_l.push_back(char_at(hash_in, hex_mode, j, 1'b1));
          q_u.push_back(char_at(hash_in, hex_mode, j, 1'b0));
        end
      end else if (rise) m_ovr = 1'b1;
      m_prev = hash_done;
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    hash_done = 1'b1;
    step();
    hash_done = 1'b0;
  endtask

  // wait until exactly n bytes of the current digest remain
  task automatic wait_left(int n, int budget);
    int c = 0;
    while (q_l.size() != n && c < budget) begin
      step();
      c++;
    end
    checks++;
    if (q_l.size() != n) begin
      errors++;
      $display("FAIL wait_left timeout at %0t: got %0d bytes left expected %0d", $time, q_l.size(), n);
    end
  endtask

  task automatic clear_logs();
    log_l.delete();
    log_u.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    chk("pin_raw0", char_at(ABC, 1'b0, 0, 1'b1), 8'hba);
    chk("pin_raw31", char_at(ABC, 1'b0, 31, 1'b1), 8'had);
    chk("pin_hex0_lo", char_at(ABC, 1'b1, 0, 1'b1), 8'h62);
    chk("pin_hex0_up", char_at(ABC, 1'b1, 0, 1'b0), 8'h42);
    chk("pin_hex63_lo", char_at(ABC, 1'b1, 63, 1'b1), 8'h64);
    step(3);
    rst = 1'b0;
    step(2);
    // raw digest with a free-flowing sink; hash_in changes after capture
    clear_logs();
    hash_in = ABC;
    dout_ready = 1'b1;
    pulse();
    hash_in = rnd256();
    wait_left(0, 100);
    step();
    chk("raw_len", 8'(log_l.size()), 8'd32);
    if (log_l.size() == 32) begin
      chk("raw_first", log_l[0], 8'hba);
      chk("raw_idx10", log_l[10], 8'h40);
      chk("raw_final", log_l[31], 8'had);
    end
    // hex digest; hex_mode drops mid-digest
    clear_logs();
    hash_in = ABC;
    hex_mode = 1'b1;
    pulse();
    hex_mode = 1'b0;
    wait_left(0, 200);
    step();
    chk("hex_len", 8'(log_l.size()), 8'd64);
    if (log_l.size() == 64 && log_u.size() == 64) begin
      chk("hex_c0_lo", log_l[0], 8'h62);
      chk("hex_c1_lo", log_l[1], 8'h61);
      chk("hex_c0_up", log_u[0], 8'h42);
      chk("hex_c63_up", log_u[63], 8'h44);
    end
    // raw digest with a stalling sink
    clear_logs();
    hash_in = ABC;
    pulse();
    for (int c = 0; c < 400 && q_l.size() != 0; c++) begin
      dout_ready = 1'($urandom_range(0, 1));
      step();
    end
    dout_ready = 1'b1;
    wait_left(0, 50);
    step();
    chk("stall_len", 8'(log_l.size()), 8'd32);
    if (log_l.size() == 32) begin
      chk("stall_first", log_l[0], 8'hba);
      chk("stall_final", log_l[31], 8'had);
    end
    // second edge at byte index 10 is dropped and flagged
    clear_logs();
    hash_in = ABC;
    pulse();
    wait_left(22, 50);
    hash_in = ~ABC;
    pulse();
    chk("ovr_set", {7'b0, ovr_l}, 8'd1);
    wait_left(0, 50);
    step(3);
    chk("ovr_len", 8'(log_l.size()), 8'd32);
    if (log_l.size() == 32) chk("ovr_tail", log_l[31], 8'had);
    // edge on the final transfer chains straight into the next digest
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step();
    hash_in = ABC;
    pulse();
    wait_left(1, 50);
    hash_in = rnd256();
    hash_done = 1'b1;
    step();
    hash_done = 1'b0;
    chk("chain_valid", {7'b0, v_l}, 8'd1);
    chk("chain_byte0", dout_l, char_at(hash_in, 1'b0, 0, 1'b1));
    chk("chain_ovr", {7'b0, ovr_l}, 8'd0);
    wait_left(0, 50);
    // reset at index 5 with hash_done held high restarts from byte 0
    hash_in = ABC;
    pulse();
    wait_left(27, 50);
    rst = 1'b1;
    hash_done = 1'b1;
    step(3);
    chk("rst_dout", dout_l, 8'h00);
    chk("rst_valid", {7'b0, v_l}, 8'd0);
    rst = 1'b0;
    step();
    chk("rel_valid", {7'b0, v_l}, 8'd1);
    chk("rel_byte0", dout_l, 8'hba);
    hash_done = 1'b0;
    wait_left(0, 50);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      dout_ready = ($urandom_range(0, 9) < 7);
      hash_done = ($urandom_range(0, 19) == 0) ? 1'b1 : (hash_done && $urandom_range(0, 3) != 0);
      hex_mode = 1'($urandom_range(0, 1));
      hash_in = rnd256();
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
